// File: rtl/mshr_retire_ctrl_if.sv
// rtl/mshr_retire_ctrl_if.sv - FIFO drain, WB response and scoreboard release bundle
// master is the retire controller; slave is the FIFO/WB/scoreboard side.
interface mshr_retire_ctrl_if #(
  parameter int DATA_WIDTH = 74
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_ren;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [2:0]            wb_warp_id;
  logic [7:0]            wb_active_mask;
  logic [26:0]           wb_line_addr;
  logic [23:0]           wb_word_addr;
  logic                  sb_release_valid;
  logic [2:0]            sb_release_warp;
  logic [1:0]            sb_release_entry;

  modport master (
    input  fifo_empty, fifo_dout, wb_ready,
    output fifo_ren, wb_valid, wb_warp_id, wb_active_mask, wb_line_addr, wb_word_addr,
           sb_release_valid, sb_release_warp, sb_release_entry
  );

  modport slave (
    output fifo_empty, fifo_dout, wb_ready,
    input  fifo_ren, wb_valid, wb_warp_id, wb_active_mask, wb_line_addr, wb_word_addr,
           sb_release_valid, sb_release_warp, sb_release_entry
  );
endinterface

// File: rtl/mshr_retire_ctrl.sv
// rtl/mshr_retire_ctrl.sv - MSHR miss FIFO drain: latency countdown, load response, release
// Pops one entry, counts down its latency, then retires it (loads via WB handshake).
module mshr_retire_ctrl #(
  parameter int DATA_WIDTH = 74,
  parameter int EXTRA_LAT  = 0,
  parameter int CNT_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mshr_retire_ctrl_if.master  bus,
  output logic                busy,
  output logic [15:0]         retire_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] head;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_init;
  logic                  head_is_load;
  logic                  in_resp;
  logic                  retire;
  logic                  pop;
  logic                  unused_head;

  assign head_is_load = head[73];
  assign in_resp      = (state == RESP);
  assign retire       = in_resp && (!head_is_load || bus.wb_ready);
  // Gated by rst_n so nothing is popped while reset is held.
  assign pop          = rst_n && !bus.fifo_empty && ((state == IDLE) || retire);
  assign cnt_init     = CNT_W'(bus.fifo_dout[18:16]) + CNT_W'(EXTRA_LAT);

  assign bus.fifo_ren         = pop;
  assign bus.wb_valid         = in_resp && head_is_load;
  assign bus.wb_line_addr     = in_resp ? head[72:46] : '0;
  assign bus.wb_word_addr     = in_resp ? head[45:22] : '0;
  assign bus.wb_warp_id       = in_resp ? head[21:19] : '0;
  assign bus.wb_active_mask   = in_resp ? head[15:8]  : '0;
  assign bus.sb_release_valid = retire && head[7];
  assign bus.sb_release_warp  = in_resp ? head[21:19] : '0;
  assign bus.sb_release_entry = in_resp ? head[6:5]   : '0;
  assign busy                 = (state != IDLE);

  // Latency is consumed at pop time; reserved bits are never looked at.
  assign unused_head = ^{head[18:16], head[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      head       <= '0;
      cnt        <= '0;
      retire_cnt <= '0;
    end else begin
      if (retire) begin
        retire_cnt <= retire_cnt + 16'd1;
      end
      if (pop) begin
        head  <= bus.fifo_dout;
        cnt   <= cnt_init;
        state <= COUNT;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          COUNT: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              state <= RESP;
            end
          end
          RESP: begin
            if (retire) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/mshr_retire_ctrl.md
Name: mshr_retire_ctrl

Overview:
Drain side of the MSHR miss FIFO. It pops one miss entry at a time and counts down that entry's latency field to model miss-service time. Loads are then delivered to the WB stage over a valid/ready handshake; stores retire silently. On retire it issues the scoreboard release carried in the entry.

Parameters:
DATA_WIDTH, 74, MSHR entry width. Field layout is fixed below; bits [4:0] are reserved and ignored.
EXTRA_LAT, 0, cycles added to every entry's latency field (0..8).
CNT_W, 4, countdown counter width. Must satisfy 2^CNT_W > 7+EXTRA_LAT.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
fifo_empty  in  1  MSHR FIFO empty flag
fifo_dout  in  DATA_WIDTH  MSHR FIFO head entry; combinational, valid when !fifo_empty
fifo_ren  out  1  pop strobe; the FIFO advances on the clk edge where this is high
wb_valid  out  1  load response valid
wb_ready  in  1  WB stage accepts the response
wb_warp_id  out  3  warp ID of the response
wb_active_mask  out  8  active thread mask
wb_line_addr  out  27  cache line address
wb_word_addr  out  24  per-thread word offsets, 8 x 3 bit
sb_release_valid  out  1  one-cycle scoreboard release pulse
sb_release_warp  out  3  warp whose scoreboard entry is released
sb_release_entry  out  2  scoreboard entry number released
busy  out  1  an entry is held (state != IDLE)
retire_cnt  out  16  count of retired entries; wraps at 2^16

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Entry fields:
  - [73] lw_swbar (1 = load)
  - [72:46] line address
  - [45:22] word addresses
  - [21:19] warp ID
  - [18:16] latency L
  - [15:8] active mask
  - [7] sb release valid
  - [6:5] sb release entry
- Reset state: IDLE. Head register, counter and retire_cnt are cleared. All outputs are 0.
- Reset mid-operation: the held entry is discarded with no release and no WB. The FIFO is not popped.
- States: IDLE, COUNT, RESP.
- IDLE:
  - fifo_ren = !fifo_empty, combinational.
  - On the pop edge: latch fifo_dout into the head register, load cnt = L + EXTRA_LAT, and go to COUNT.
- COUNT:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, go to RESP on the next edge.
  - No pop occurs in COUNT.
- RESP, load entry:
  - wb_valid = 1. All wb_* outputs are driven from the head register.
  - wb_valid and all wb_* fields hold stable until wb_ready is sampled high.
  - The retire event is wb_valid & wb_ready.
- RESP, store entry:
  - wb_valid stays 0.
  - The retire event occurs in the first RESP cycle; the state lasts exactly one cycle.
- Retire cycle:
  - sb_release_valid = head sb valid bit, combinational, high for that single cycle only.
  - sb_release_warp and sb_release_entry are driven from the head register.
  - retire_cnt increments on that edge.
  - If !fifo_empty: fifo_ren = 1, the next entry is latched, and the state goes to COUNT (back-to-back).
  - Otherwise the state goes to IDLE.
- Timing (ready high, EXTRA_LAT = 0): with pop edge at cycle 0, COUNT spans cycles 1..L+1 and RESP/retire is at cycle L+2.
- Rate: at most one pop per clock, and only in IDLE or a retire cycle. fifo_ren is never high while fifo_empty = 1.
- Outside RESP: wb_* fields and sb_release_warp/entry are 0.
- busy = (state != IDLE).

Test Plan:
- Single load, L=3, mask=8'hA5, warp=5, sb valid=1, entry=2, wb_ready=1 -> fifo_ren for 1 cycle; wb_valid 5 cycles after the pop edge with all fields matching; sb_release_valid 1 cycle (warp 5, entry 2); retire_cnt=1; return to IDLE.
- Store, L=0, sb valid=1 -> wb_valid never asserts; sb_release_valid pulses 2 cycles after the pop edge; retire_cnt increments.
- Load L=1 with wb_ready low for 4 RESP cycles -> wb_valid and fields stable for 4 cycles; no fifo_ren and no release until ready; retire on the 5th cycle.
- Two loads queued, L=0 and L=2, ready high -> second fifo_ren in the first retire cycle with no IDLE gap; second wb_valid 4 cycles later; retire_cnt=2.
- rst_n asserted mid-COUNT, L=7 -> all outputs 0 immediately (asynchronous); after release, the next FIFO entry is popped normally; the discarded entry produces no release.
- Entry with sb valid=0; EXTRA_LAT=4 build with L=2 -> no sb_release_valid; wb_valid 8 cycles after the pop edge.
